// File: rtl/mem_if_pkg.sv
// rtl/mem_if_pkg.sv - shared encodings and helpers for the memory bus controller
//
// Purpose: access-size and fault encodings, FSM state constants, the registered
// request record and the byte-lane/alignment helpers used by the controller.
// Ports: none (package).
package mem_if_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_RSVD = 2'b11;

  localparam logic [1:0] FAULT_NONE       = 2'b00;
  localparam logic [1:0] FAULT_MISALIGNED = 2'b01;
  localparam logic [1:0] FAULT_UNMAPPED   = 2'b10;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  typedef struct packed {
    logic        write;
    logic [1:0]  size;
    logic        is_unsigned;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  // Byte lanes touched by an access of the given size at the given byte offset.
  function automatic logic [3:0] lane_enable(input logic [1:0] size, input logic [1:0] offset);
    case (size)
      SIZE_BYTE: return 4'b0001 << offset;
      SIZE_HALF: return 4'b0011 << offset;
      SIZE_WORD: return 4'b1111;
      default:   return 4'b0000;
    endcase
  endfunction

  // The reserved size never aligns, so it always reports as misaligned.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
    case (size)
      SIZE_BYTE: return 1'b0;
      SIZE_HALF: return offset[0];
      SIZE_WORD: return offset != 2'b00;
      default:   return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_bank.sv
// rtl/mem_bank.sv - single-port byte-enabled RAM bank with pipelined read
//
// Purpose: one on-chip RAM region. Writes commit on the rising edge where wren
// is high; read data for an address appears READ_LATENCY edges later.
// Ports:
//   iCLK     in  clock
//   address  in  word address within the bank
//   byteena  in  per-byte write enables
//   data     in  write data (already lane-replicated)
//   wren     in  write strobe
//   q        out registered read data
module mem_bank #(
  parameter int WORDS_LOG2   = 12,
  parameter int READ_LATENCY = 1,
  parameter     INIT_FILE    = "mem0.mif"
) (
  input  logic                  iCLK,
  input  logic [WORDS_LOG2-1:0] address,
  input  logic [3:0]            byteena,
  input  logic [31:0]           data,
  input  logic                  wren,
  output logic [31:0]           q
);

  logic [31:0] mem_q  [2**WORDS_LOG2];
  logic [31:0] pipe_q [READ_LATENCY];

  // Preload comes from INIT_FILE through the implementation flow's RAM
  // inference; in simulation the array starts undefined.
  if ($bits(INIT_FILE) > 0) begin : g_init_file
  end

  always_ff @(posedge iCLK) begin
    if (wren) begin
      for (int b = 0; b < 4; b++) begin
        if (byteena[b]) mem_q[address][8*b +: 8] <= data[8*b +: 8];
      end
    end
    // Read-during-write returns the old word.
    pipe_q[0] <= mem_q[address];
    for (int i = 1; i < READ_LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
  end

  assign q = pipe_q[READ_LATENCY-1];

endmodule

// File: rtl/memory_bus_controller.sv
// rtl/memory_bus_controller.sv - load/store front-end to on-chip RAM banks
//
// Purpose: accepts one load/store at a time, checks alignment, decodes the
// address into a RAM bank, steers byte lanes, extends load data and returns a
// registered response (with fault code) for every request.
// Ports:
//   iCLK, iRST_N            clock, synchronous active-low reset
//   wReqValid/wReqReady     request handshake
//   wReqWrite, wReqSize, wReqUnsigned, wReqAddress, wReqWriteData  request payload
//   wRspValid/wRspReady     response handshake
//   wRspReadData, wRspFault response payload
//   wBusy                   FSM not idle
module memory_bus_controller
  import mem_if_pkg::*;
#(
  parameter int                        NUM_REGIONS       = 2,
  parameter logic [32*NUM_REGIONS-1:0] REGION_BASE       = {32'h1001_0000, 32'h0040_0000},
  parameter logic [8*NUM_REGIONS-1:0]  REGION_WORDS_LOG2 = {8'd12, 8'd12},
  parameter int                        READ_LATENCY      = 1,
  parameter                            INIT_FILE_PREFIX  = "mem"
) (
  input  logic        iCLK,
  input  logic        iRST_N,
  input  logic        wReqValid,
  output logic        wReqReady,
  input  logic        wReqWrite,
  input  logic [1:0]  wReqSize,
  input  logic        wReqUnsigned,
  input  logic [31:0] wReqAddress,
  input  logic [31:0] wReqWriteData,
  output logic        wRspValid,
  input  logic        wRspReady,
  output logic [31:0] wRspReadData,
  output logic [1:0]  wRspFault,
  output logic        wBusy
);

  logic [1:0]  state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        first_q, first_d;
  req_t        req_q, req_d;
  logic [1:0]  sel_q, sel_d;
  logic [1:0]  fault_q, fault_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic [1:0]  rsp_fault_q, rsp_fault_d;

  logic        hit;
  logic [1:0]  hit_idx;
  logic [1:0]  in_fault;
  logic [3:0]  byteena;
  logic [31:0] wdata_rep;
  logic [31:0] bank_q [4];

  function automatic logic in_region(input logic [31:0] addr, input logic [31:0] base,
                                     input logic [7:0] wl);
    logic [32:0] limit;
    // One extra bit so a region ending at the top of the address space does not wrap.
    limit = {1'b0, base} + (33'd4 << wl);
    return (addr >= base) && ({1'b0, addr} < limit);
  endfunction

  function automatic logic [31:0] extend_load(input logic [31:0] word, input logic [1:0] size,
                                              input logic [1:0] offset, input logic uns);
    logic [15:0] sh;
    sh = 16'(word >> {offset, 3'b000});
    case (size)
      SIZE_BYTE: return uns ? {24'd0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
      SIZE_HALF: return uns ? {16'd0, sh}      : {{16{sh[15]}}, sh};
      default:   return word;
    endcase
  endfunction

  // Scan from the highest index down so the lowest overlapping region wins.
  always_comb begin
    hit     = 1'b0;
    hit_idx = 2'd0;
    for (int r = NUM_REGIONS - 1; r >= 0; r--) begin
      if (in_region(wReqAddress, REGION_BASE[32*r +: 32], REGION_WORDS_LOG2[8*r +: 8])) begin
        hit     = 1'b1;
        hit_idx = 2'(r);
      end
    end
  end

  // Alignment takes precedence over decode.
  assign in_fault = is_misaligned(wReqSize, wReqAddress[1:0]) ? FAULT_MISALIGNED :
                    (hit ? FAULT_NONE : FAULT_UNMAPPED);

  assign byteena = lane_enable(req_q.size, req_q.addr[1:0]);

  always_comb begin
    case (req_q.size)
      SIZE_BYTE: wdata_rep = {4{req_q.wdata[7:0]}};
      SIZE_HALF: wdata_rep = {2{req_q.wdata[15:0]}};
      default:   wdata_rep = req_q.wdata;
    endcase
  end

  for (genvar g = 0; g < 4; g++) begin : g_bank
    if (g < NUM_REGIONS) begin : g_used
      localparam int          WL   = int'(REGION_WORDS_LOG2[8*g +: 8]);
      localparam logic [31:0] BASE = REGION_BASE[32*g +: 32];

      logic [WL-1:0] word_addr;
      logic          wren;

      assign word_addr = WL'((req_q.addr - BASE) >> 2);
      // first_q is only ever set for a non-faulting request, and iRST_N kills
      // a strobe that is in flight when reset arrives.
      assign wren = first_q && req_q.write && iRST_N && (sel_q == 2'(g));

      mem_bank #(
        .WORDS_LOG2  (WL),
        .READ_LATENCY(READ_LATENCY),
        .INIT_FILE   ({INIT_FILE_PREFIX, 8'(48 + g), ".mif"})
      ) u_bank (
        .iCLK   (iCLK),
        .address(word_addr),
        .byteena(byteena),
        .data   (wdata_rep),
        .wren   (wren),
        .q      (bank_q[g])
      );
    end else begin : g_unused
      assign bank_q[g] = 32'd0;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    first_d     = 1'b0;
    req_d       = req_q;
    sel_d       = sel_q;
    fault_d     = fault_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_fault_d = rsp_fault_q;
    case (state_q)
      ST_IDLE: begin
        if (wReqValid) begin
          req_d = '{write: wReqWrite, size: wReqSize, is_unsigned: wReqUnsigned,
                    addr: wReqAddress, wdata: wReqWriteData};
          sel_d   = hit_idx;
          fault_d = in_fault;
          if (in_fault != FAULT_NONE) begin
            state_d = ST_RESP;
          end else begin
            state_d = ST_ACCESS;
            first_d = 1'b1;
            cnt_d   = wReqWrite ? 3'd1 : 3'(READ_LATENCY);
          end
        end
      end
      ST_ACCESS: begin
        if (cnt_q == 3'd0) begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_fault_d = FAULT_NONE;
          rsp_data_d  = req_q.write ? 32'd0 :
                        extend_load(bank_q[sel_q], req_q.size, req_q.addr[1:0], req_q.is_unsigned);
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      ST_RESP: begin
        // A fault enters RESP straight from IDLE, so its response is raised
        // one cycle after accept rather than on the accept edge.
        if (!rsp_valid_q) begin
          rsp_valid_d = 1'b1;
          rsp_fault_d = fault_q;
          rsp_data_d  = 32'd0;
        end else if (wRspReady) begin
          rsp_valid_d = 1'b0;
          rsp_fault_d = FAULT_NONE;
          rsp_data_d  = 32'd0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 3'd0;
      first_q     <= 1'b0;
      req_q       <= '0;
      sel_q       <= 2'd0;
      fault_q     <= FAULT_NONE;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 32'd0;
      rsp_fault_q <= FAULT_NONE;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      first_q     <= first_d;
      req_q       <= req_d;
      sel_q       <= sel_d;
      fault_q     <= fault_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_fault_q <= rsp_fault_d;
    end
  end

  assign wReqReady    = iRST_N && (state_q == ST_IDLE);
  assign wRspValid    = rsp_valid_q;
  assign wRspReadData = rsp_data_q;
  assign wRspFault    = rsp_fault_q;
  assign wBusy        = state_q != ST_IDLE;

endmodule

// File: tb/tb_memory_bus_controller.sv
// tb/tb_memory_bus_controller.sv - scoreboard bench for memory_bus_controller
module tb_memory_bus_controller;
  import mem_if_pkg::*;

  logic        iCLK = 1'b0;
  logic        iRST_N;
  logic        wReqValid, wReqReady, wReqWrite, wReqUnsigned;
  logic [1:0]  wReqSize;
  logic [31:0] wReqAddress, wReqWriteData;
  logic        wRspValid, wRspReady;
  logic [31:0] wRspReadData;
  logic [1:0]  wRspFault;
  logic        wBusy;

  always #5 iCLK = ~iCLK;

  memory_bus_controller #(
    .NUM_REGIONS      (2),
    .REGION_BASE      ({32'h1001_0000, 32'h0040_0000}),
    .REGION_WORDS_LOG2({8'd12, 8'd12}),
    .READ_LATENCY     (1),
    .INIT_FILE_PREFIX ("mem")
  ) dut (
    .iCLK         (iCLK),
    .iRST_N       (iRST_N),
    .wReqValid    (wReqValid),
    .wReqReady    (wReqReady),
    .wReqWrite    (wReqWrite),
    .wReqSize     (wReqSize),
    .wReqUnsigned (wReqUnsigned),
    .wReqAddress  (wReqAddress),
    .wReqWriteData(wReqWriteData),
    .wRspValid    (wRspValid),
    .wRspReady    (wRspReady),
    .wRspReadData (wRspReadData),
    .wRspFault    (wRspFault),
    .wBusy        (wBusy)
  );

  typedef struct {
    string       name;
    logic [31:0] data;
    logic [1:0]  fault;
    int          lat;
    int          hold;
    int          acc;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass = 0;
  int   cyc = 0;
  bit   outstanding = 1'b0;

  always @(posedge iCLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
  endtask

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic issue(input string name, input logic wr, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] exp_data, input logic [1:0] exp_fault, input int hold);
    int   guard;
    exp_t e;
    wReqValid = 1'b1; wReqWrite = wr; wReqSize = sz; wReqUnsigned = uns;
    wReqAddress = addr; wReqWriteData = wd;
    guard = 0;
    while (wReqReady !== 1'b1 && guard < 300) begin
      @(negedge iCLK);
      guard++;
    end
    if (guard >= 300) begin
      chk({name, " accept timeout"}, 32'd0, 32'd1);
      wReqValid = 1'b0;
      return;
    end
    chk({name, " single outstanding"}, {31'd0, outstanding}, 32'd0);
    e.name = name; e.data = exp_data; e.fault = exp_fault; e.hold = hold;
    e.lat  = (exp_fault != FAULT_NONE) ? 1 : (wr ? 2 : 2);
    e.acc  = cyc + 1;
    sb_q.push_back(e);
    outstanding = 1'b1;
    @(posedge iCLK);
    @(negedge iCLK);
    wReqValid = 1'b0;
  endtask

  task automatic ld(input string name, input logic [1:0] sz, input logic uns, input logic [31:0] addr,
                    input logic [31:0] exp_data, input logic [1:0] exp_fault);
    issue(name, 1'b0, sz, uns, addr, 32'd0, exp_data, exp_fault, 0);
  endtask

  task automatic st(input string name, input logic [1:0] sz, input logic [31:0] addr,
                    input logic [31:0] wd, input logic [1:0] exp_fault);
    issue(name, 1'b1, sz, 1'b0, addr, wd, 32'd0, exp_fault, 0);
  endtask

  // Monitor: pops the scoreboard on each new response and drives wRspReady.
  initial begin : monitor
    exp_t        cur;
    bit          in_rsp;
    int          hold_left;
    logic [31:0] held_d;
    logic [1:0]  held_f;
    in_rsp = 1'b0;
    hold_left = 0;
    wRspReady = 1'b0;
    forever begin
      @(negedge iCLK);
      if (iRST_N !== 1'b1) begin
        in_rsp = 1'b0;
        wRspReady = 1'b0;
      end else if (!in_rsp) begin
        if (wRspValid === 1'b1) begin
          if (sb_q.size() == 0) begin
            chk("unexpected response", 32'd1, 32'd0);
            cur.name = "unexpected"; cur.hold = 0;
          end else begin
            cur = sb_q.pop_front();
            chk({cur.name, " latency"}, 32'(cyc - cur.acc), 32'(cur.lat));
            chk({cur.name, " data"}, wRspReadData, cur.data);
            chk({cur.name, " fault"}, {30'd0, wRspFault}, {30'd0, cur.fault});
          end
          held_d = wRspReadData;
          held_f = wRspFault;
          hold_left = cur.hold;
          in_rsp = 1'b1;
          if (hold_left == 0) begin
            wRspReady = 1'b1;
            outstanding = 1'b0;
          end
        end
      end else if (wRspReady) begin
        chk({cur.name, " valid drops after handshake"}, {31'd0, wRspValid}, 32'd0);
        in_rsp = 1'b0;
        wRspReady = 1'b0;
      end else begin
        chk({cur.name, " hold valid"}, {31'd0, wRspValid}, 32'd1);
        chk({cur.name, " hold data"}, wRspReadData, held_d);
        chk({cur.name, " hold fault"}, {30'd0, wRspFault}, {30'd0, held_f});
        chk({cur.name, " hold req ready low"}, {31'd0, wReqReady}, 32'd0);
        hold_left--;
        if (hold_left == 0) begin
          wRspReady = 1'b1;
          outstanding = 1'b0;
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : stimulus
    int guard;
    iRST_N = 1'b0; wReqValid = 1'b0; wReqWrite = 1'b0; wReqSize = SIZE_WORD;
    wReqUnsigned = 1'b0; wReqAddress = 32'd0; wReqWriteData = 32'd0;
    repeat (3) @(negedge iCLK);
    chk("reset req ready", {31'd0, wReqReady}, 32'd0);
    chk("reset rsp valid", {31'd0, wRspValid}, 32'd0);
    chk("reset rsp data", wRspReadData, 32'd0);
    chk("reset rsp fault", {30'd0, wRspFault}, 32'd0);
    chk("reset busy", {31'd0, wBusy}, 32'd0);
    iRST_N = 1'b1;
    @(negedge iCLK);
    chk("post reset req ready", {31'd0, wReqReady}, 32'd1);

    st("st word", SIZE_WORD, 32'h1001_0004, 32'hDEAD_BEEF, FAULT_NONE);
    ld("ld word", SIZE_WORD, 1'b0, 32'h1001_0004, 32'hDEAD_BEEF, FAULT_NONE);
    st("st byte", SIZE_BYTE, 32'h1001_0007, 32'h0000_0080, FAULT_NONE);
    ld("ld byte s", SIZE_BYTE, 1'b0, 32'h1001_0007, 32'hFFFF_FF80, FAULT_NONE);
    ld("ld byte u", SIZE_BYTE, 1'b1, 32'h1001_0007, 32'h0000_0080, FAULT_NONE);
    ld("ld word after byte", SIZE_WORD, 1'b0, 32'h1001_0004, 32'h80AD_BEEF, FAULT_NONE);
    ld("ld half s", SIZE_HALF, 1'b0, 32'h1001_0004, 32'hFFFF_BEEF, FAULT_NONE);
    ld("ld half u", SIZE_HALF, 1'b1, 32'h1001_0006, 32'h0000_80AD, FAULT_NONE);
    ld("ld byte u off1", SIZE_BYTE, 1'b1, 32'h1001_0005, 32'h0000_00BE, FAULT_NONE);

    ld("ld half misaligned", SIZE_HALF, 1'b0, 32'h1001_0003, 32'd0, FAULT_MISALIGNED);
    st("st half misaligned", SIZE_HALF, 32'h1001_0005, 32'h0000_1234, FAULT_MISALIGNED);
    ld("ld word after bad st", SIZE_WORD, 1'b0, 32'h1001_0004, 32'h80AD_BEEF, FAULT_NONE);
    ld("ld unmapped", SIZE_WORD, 1'b0, 32'h2000_0000, 32'd0, FAULT_UNMAPPED);
    ld("ld misaligned unmapped", SIZE_WORD, 1'b0, 32'h2000_0002, 32'd0, FAULT_MISALIGNED);
    ld("ld reserved size", SIZE_RSVD, 1'b0, 32'h1001_0004, 32'd0, FAULT_MISALIGNED);
    st("st unmapped", SIZE_WORD, 32'h0040_4000, 32'h5555_5555, FAULT_UNMAPPED);
    ld("ld below base", SIZE_WORD, 1'b0, 32'h003F_FFFC, 32'd0, FAULT_UNMAPPED);

    st("st r0 word", SIZE_WORD, 32'h0040_0000, 32'h0102_0304, FAULT_NONE);
    ld("ld r0 byte3", SIZE_BYTE, 1'b0, 32'h0040_0003, 32'h0000_0001, FAULT_NONE);
    st("st r0 half", SIZE_HALF, 32'h0040_0002, 32'hFFFF_8001, FAULT_NONE);
    ld("ld r0 word", SIZE_WORD, 1'b0, 32'h0040_0000, 32'h8001_0304, FAULT_NONE);
    ld("ld r0 half s", SIZE_HALF, 1'b0, 32'h0040_0002, 32'hFFFF_8001, FAULT_NONE);
    st("st r0 last word", SIZE_WORD, 32'h0040_3FFC, 32'hA5A5_1234, FAULT_NONE);
    ld("ld r0 last word", SIZE_WORD, 1'b0, 32'h0040_3FFC, 32'hA5A5_1234, FAULT_NONE);

    issue("ld held", 1'b0, SIZE_WORD, 1'b0, 32'h1001_0004, 32'd0, 32'h80AD_BEEF, FAULT_NONE, 5);
    ld("ld after held", SIZE_BYTE, 1'b1, 32'h1001_0004, 32'h0000_00EF, FAULT_NONE);

    // Store aborted by reset in its first ACCESS cycle must not reach RAM.
    st("st keep", SIZE_WORD, 32'h1001_0008, 32'hCAFE_F00D, FAULT_NONE);
    wReqValid = 1'b1; wReqWrite = 1'b1; wReqSize = SIZE_WORD; wReqUnsigned = 1'b0;
    wReqAddress = 32'h1001_0008; wReqWriteData = 32'h1122_3344;
    guard = 0;
    while (wReqReady !== 1'b1 && guard < 300) begin
      @(negedge iCLK);
      guard++;
    end
    chk("abort st accepted", {31'd0, wReqReady}, 32'd1);
    @(posedge iCLK);
    @(negedge iCLK);
    wReqValid = 1'b0;
    iRST_N = 1'b0;
    @(negedge iCLK);
    chk("mid reset req ready", {31'd0, wReqReady}, 32'd0);
    chk("mid reset rsp valid", {31'd0, wRspValid}, 32'd0);
    chk("mid reset rsp data", wRspReadData, 32'd0);
    chk("mid reset rsp fault", {30'd0, wRspFault}, 32'd0);
    chk("mid reset busy", {31'd0, wBusy}, 32'd0);
    iRST_N = 1'b1;
    @(negedge iCLK);
    chk("after mid reset ready", {31'd0, wReqReady}, 32'd1);
    ld("ld after abort", SIZE_WORD, 1'b0, 32'h1001_0008, 32'hCAFE_F00D, FAULT_NONE);

    guard = 0;
    while ((sb_q.size() != 0 || outstanding) && guard < 200) begin
      @(negedge iCLK);
      guard++;
    end
    chk("scoreboard drained", 32'(sb_q.size()), 32'd0);
    repeat (3) @(negedge iCLK);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
